sq_wave_gen_multi: RTL

Parametrised multi-channel successor to the single-channel square-wave generator. Each channel produces a wave that is high for m ticks and low for n ticks. A shared prescaler sets the tick period. New m/n values are written into shadow registers and take effect only at a period boundary, so the output never glitches. Each channel has its own enable and a period-done pulse; the block sits between the control registers/switch inputs and the output pins.

---
 rtl/sq_wave_gen_multi_pkg.sv | 11 +
 rtl/sq_wave_gen_multi_chan.sv | 89 ++++++++
 rtl/sq_wave_gen_multi.sv | 50 +++++
 3 files changed

// File: rtl/sq_wave_gen_multi_pkg.sv
// Shared types and helpers for the multi-channel square-wave generator.
package sq_wave_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} sq_state_t;

  // Prescaler counter width; never narrower than one bit.
  function automatic int pre_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sq_wave_gen_multi_chan.sv
// One square-wave channel: shadow/active m,n registers, phase FSM and tick down-counter.
//
// state | meaning
// IDLE  | output low, waiting for en and a tick (or both m/n are zero)
// HIGH  | output high for active_m ticks
// LOW   | output low for active_n ticks
module sq_wave_chan
  import sq_wave_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] m,
  input  logic [W-1:0] n,
  output logic         wave_out,
  output logic         period_done
);

  sq_state_t    state;
  sq_state_t    start_state;
  logic [W-1:0] shadow_m, shadow_n;
  logic [W-1:0] active_m, active_n;
  logic [W-1:0] tick_cnt;
  logic [W-1:0] start_cnt;
  logic         period_end;
  logic         restart;

  // tick_cnt holds ticks remaining in the phase minus one; zero is terminal count.
  always_comb begin
    start_state = IDLE;
    start_cnt   = '0;
    if (shadow_m != '0) begin
      start_state = HIGH;
      start_cnt   = shadow_m - 1'b1;
    end else if (shadow_n != '0) begin
      start_state = LOW;
      start_cnt   = shadow_n - 1'b1;
    end
  end

  assign period_end = tick && (tick_cnt == '0) &&
                      ((state == LOW) || ((state == HIGH) && (active_n == '0)));
  assign restart    = tick && ((state == IDLE) || period_end);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shadow_m    <= '0;
      shadow_n    <= '0;
      active_m    <= '0;
      active_n    <= '0;
      tick_cnt    <= '0;
      wave_out    <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (load) begin
        shadow_m <= m;
        shadow_n <= n;
      end
      if (!en) begin
        state    <= IDLE;
        tick_cnt <= '0;
        wave_out <= 1'b0;
      end else if (restart) begin
        // Period start uses the pre-edge shadow, so a coincident load waits a period.
        active_m    <= shadow_m;
        active_n    <= shadow_n;
        state       <= start_state;
        tick_cnt    <= start_cnt;
        wave_out    <= (start_state == HIGH);
        period_done <= period_end;
      end else if (tick) begin
        if (tick_cnt != '0) begin
          tick_cnt <= tick_cnt - 1'b1;
        end else if (state == HIGH) begin
          state    <= LOW;
          tick_cnt <= active_n - 1'b1;
          wave_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sq_wave_gen_multi.sv
// Multi-channel square-wave generator: shared tick prescaler feeding CH independent channels.
module sq_wave_gen_multi
  import sq_wave_pkg::*;
#(
  parameter int CH       = 2,
  parameter int W        = 8,
  parameter int TICK_DIV = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   load,
  input  logic [CH*W-1:0] m,
  input  logic [CH*W-1:0] n,
  output logic [CH-1:0]   wave_out,
  output logic [CH-1:0]   period_done
);

  localparam int PW = pre_w(TICK_DIV);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    sq_wave_chan #(.W(W)) u_chan (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .en         (en[i]),
      .load       (load[i]),
      .m          (m[i*W +: W]),
      .n          (n[i*W +: W]),
      .wave_out   (wave_out[i]),
      .period_done(period_done[i])
    );
  end

endmodule
